// File: rtl/eng_sim_in_pkg.sv
// eng_sim_in_pkg: register addresses and edge-mode encodings for the sim input port
package eng_sim_in_pkg;
  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_COUNT = 2'd2;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/eng_sim_in_filter.sv
// eng_sim_in_filter: two-flop synchroniser plus stability filter for one input bit
module eng_sim_in_filter #(
  parameter int FILTER_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic filtered
);
  logic s1, s2;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end
  if (FILTER_CYCLES == 0) begin : g_bypass
    assign filtered = s2;
  end else begin : g_filt
    localparam int CW = FILTER_CYCLES > 1 ? $clog2(FILTER_CYCLES) : 1;
    logic [CW-1:0] cnt;
    logic lvl;
    // the level only moves after s2 has disagreed with it for FILTER_CYCLES cycles in a row
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
        lvl <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign filtered = lvl;
  end
endmodule

// File: rtl/eng_sim_in_capture.sv
// eng_sim_in_capture: filtered input port with W1C edge capture, bit-0 pulse counter and irq
module eng_sim_in_capture
  import eng_sim_in_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int FILTER_CYCLES = 3,
  parameter int EDGE_MODE     = 0,
  parameter int COUNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  if (WIDTH < 1 || WIDTH > 32 || COUNT_W < 1 || COUNT_W > 32 || EDGE_MODE < 0 || EDGE_MODE > 2 ||
      FILTER_CYCLES < 0) begin : g_param_err
    $error("eng_sim_in_capture: parameter out of range");
  end
  logic [WIDTH-1:0] filtered, filtered_d, edge_v, edge_r, mask, clr;
  logic [COUNT_W-1:0] count;
  logic [31:0] rd_mux;
  logic wr_en, cnt_clr, unused_wd;
  assign unused_wd = ^writedata;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    eng_sim_in_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
      .clk      (clk),
      .reset    (reset),
      .d        (in_port[i]),
      .filtered (filtered[i])
    );
  end
  always_comb begin
    edge_v  = EDGE_MODE == EDGE_RISE ? filtered & ~filtered_d :
              EDGE_MODE == EDGE_FALL ? ~filtered & filtered_d : filtered ^ filtered_d;
    wr_en   = chipselect & write;
    clr     = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    cnt_clr = wr_en && address == ADDR_COUNT;
    rd_mux  = address == ADDR_DATA  ? 32'(filtered) :
              address == ADDR_MASK  ? 32'(mask) :
              address == ADDR_COUNT ? 32'(count) : 32'(edge_r);
  end
  // a new edge wins over a same-cycle clear, both for EDGE and for COUNT
  always_ff @(posedge clk) begin
    if (reset) begin
      filtered_d <= '0;
      edge_r     <= '0;
      mask       <= '0;
      count      <= '0;
      irq        <= 1'b0;
      readdata   <= '0;
    end else begin
      filtered_d <= filtered;
      edge_r     <= (edge_r & ~clr) | edge_v;
      if (wr_en && address == ADDR_MASK) mask <= writedata[WIDTH-1:0];
      count      <= cnt_clr ? COUNT_W'(edge_v[0]) :
                    (edge_v[0] && !(&count)) ? count + 1'b1 : count;
      irq        <= |(edge_r & mask);
      readdata   <= rd_mux;
    end
  end
endmodule

// File: tb/tb_eng_sim_in_capture.sv
// tb_eng_sim_in_capture: directed checks of filter, edge capture, irq, counter and reset
module tb_eng_sim_in_capture;
  logic clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write = 1'b0;
  logic [1:0] address = 2'd0;
  logic [31:0] writedata = '0;
  logic [7:0] in_a = '0, in_b = '0, in_c = '0;
  logic [31:0] rd_a, rd_b, rd_c;
  logic irq_a, irq_b, irq_c;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  eng_sim_in_capture dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
    .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a)
  );
  eng_sim_in_capture #(.FILTER_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
    .writedata(writedata), .readdata(rd_b), .in_port(in_b), .irq(irq_b)
  );
  eng_sim_in_capture #(.COUNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
    .writedata(writedata), .readdata(rd_c), .in_port(in_c), .irq(irq_c)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    address = a; writedata = v; chipselect = 1'b1; write = 1'b1;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask
  initial begin
    repeat (2) tick();
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick();
      chk($sformatf("reset_rd%0d", a), rd_a, 32'h0);
    end
    chk("reset_irq", {31'b0, irq_a}, 32'h0);
    address = 2'd0; in_b = 8'hA5;
    repeat (2) tick();
    chk("bypass_early", rd_b, 32'h0);
    tick();
    chk("bypass_data", rd_b, 32'hA5);
    in_a = 8'h04;
    repeat (2) tick();
    in_a = 8'h00;
    repeat (8) tick();
    chk("glitch_data", rd_a, 32'h0);
    address = 2'd3;
    tick();
    chk("glitch_edge", rd_a, 32'h0);
    address = 2'd0; in_a = 8'h04;
    repeat (5) tick();
    chk("filt_early", rd_a, 32'h0);
    tick();
    chk("filt_data", rd_a, 32'h04);
    address = 2'd3;
    tick();
    chk("filt_edge", rd_a, 32'h04);
    chk("irq_masked", {31'b0, irq_a}, 32'h0);
    wr(2'd1, 32'h04);
    chk("irq_mask_lat", {31'b0, irq_a}, 32'h0);
    tick();
    chk("irq_mask_on", {31'b0, irq_a}, 32'h1);
    address = 2'd1;
    tick();
    chk("mask_rd", rd_a, 32'h04);
    wr(2'd3, 32'h04);
    chk("irq_clr_lat", {31'b0, irq_a}, 32'h1);
    address = 2'd3;
    tick();
    chk("edge_cleared", rd_a, 32'h0);
    chk("irq_cleared", {31'b0, irq_a}, 32'h0);
    in_a = 8'h00;
    repeat (8) tick();
    chk("fall_ignored", rd_a, 32'h0);
    in_a = 8'h04;
    repeat (6) tick();
    chk("irq_pre_edge", {31'b0, irq_a}, 32'h0);
    tick();
    chk("irq_edge", {31'b0, irq_a}, 32'h1);
    chk("edge_set", rd_a, 32'h04);
    wr(2'd3, 32'h04);
    in_a = 8'h00;
    repeat (8) tick();
    in_a = 8'h04;
    repeat (5) tick();
    wr(2'd3, 32'h04);
    address = 2'd3;
    tick();
    chk("set_beats_clr", rd_a, 32'h04);
    chk("set_beats_irq", {31'b0, irq_a}, 32'h1);
    wr(2'd3, 32'h04);
    tick();
    chk("edge_w1c", rd_a, 32'h0);
    for (int p = 0; p < 20; p++) begin
      in_a[0] = (p < 10); in_c[0] = 1'b1;
      repeat (5) tick();
      in_a[0] = 1'b0; in_c[0] = 1'b0;
      repeat (5) tick();
    end
    address = 2'd2;
    tick();
    chk("count10", rd_a, 32'd10);
    chk("count_sat", rd_c, 32'd15);
    wr(2'd0, 32'hFF);
    address = 2'd0;
    tick();
    chk("data_wr_ignored", rd_a, 32'h04);
    wr(2'd2, 32'h0);
    address = 2'd2;
    tick();
    chk("count_clr", rd_a, 32'h0);
    in_a = 8'h05;
    repeat (5) tick();
    wr(2'd2, 32'h0);
    address = 2'd2;
    tick();
    chk("count_clr_edge", rd_a, 32'h1);
    in_a = 8'h25;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_irq", {31'b0, irq_a}, 32'h0);
    address = 2'd3;
    tick();
    chk("rst_edge", rd_a, 32'h0);
    address = 2'd2;
    tick();
    chk("rst_count", rd_a, 32'h0);
    address = 2'd1;
    tick();
    chk("rst_mask", rd_a, 32'h0);
    address = 2'd0;
    repeat (2) tick();
    chk("rst_data_early", rd_a, 32'h0);
    tick();
    chk("rst_data", rd_a, 32'h25);
    chk("rst_irq_after", {31'b0, irq_a}, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eng_sim_in_capture.md
Name: eng_sim_in_capture

Overview:
Parametrised successor to the engine-simulator parallel input port on the Nios II Avalon-MM bus. It synchronises and glitch-filters a WIDTH-bit external input and exposes the filtered level. It also latches per-bit edges into a write-1-to-clear capture register and counts pulses on bit 0 for RPM/crank simulation. A maskable level interrupt is raised to the CPU.

Parameters:
WIDTH, 8, number of input bits (1..32)
FILTER_CYCLES, 3, consecutive stable cycles required before the filtered level changes; 0 bypasses the filter
EDGE_MODE, 0, capture edges: 0 rising, 1 falling, 2 any
COUNT_W, 16, bit-0 pulse counter width (1..32), saturating

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
address  in  2  register select
chipselect  in  1  slave select
write  in  1  write strobe, qualified by chipselect
writedata  in  32  write data
readdata  out  32  registered read data, zero-extended
in_port  in  WIDTH  asynchronous external inputs
irq  out  1  level interrupt

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high.
- Register map:
  - 0 DATA: RO, filtered level.
  - 1 MASK: RW, WIDTH bits.
  - 2 COUNT: RO count; any write clears it.
  - 3 EDGE: write-1-to-clear capture bits.
  - Writes to address 0 are ignored.
- Reset: sync flops, filter state, filtered, filtered_d, MASK, EDGE, COUNT, readdata and irq all 0.
- Synchroniser: two flops per bit (s1, s2).
- Filter, per bit:
  - counter cnt runs 0..FILTER_CYCLES-1.
  - If s2 == filtered, cnt <= 0.
  - Else if cnt == FILTER_CYCLES-1, filtered <= s2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - A glitch shorter than FILTER_CYCLES cycles never reaches filtered.
  - FILTER_CYCLES=0: filtered is s2, no counter.
- Latency: in_port change held stable reaches filtered 2+FILTER_CYCLES edges later. DATA readdata follows one edge after that.
- Edge detect: filtered_d <= filtered every cycle. The edge vector per EDGE_MODE is built from filtered and ~filtered_d.
- EDGE update: EDGE <= (EDGE & ~clr) | edge, where clr = writedata[WIDTH-1:0] on a write to address 3. A set in the same cycle as a clear wins.
- COUNT:
  - Increments on each bit-0 edge as selected by EDGE_MODE; saturates at all-ones with no wrap.
  - Write to address 2 with a simultaneous edge: COUNT <= 1.
- irq: registered, irq <= |(EDGE & MASK), so it asserts one edge after the capture bit sets. Clearing MASK or EDGE drops irq on the following edge.
- readdata:
  - Updated every cycle from address regardless of chipselect, one-cycle read latency.
  - Register value is zero-extended to 32 bits.
  - Reflects register state before any same-cycle write.
- Reset mid-operation: all state returns to reset values on that edge. In-flight filter counts are discarded, and no edge is reported for levels present at reset release until they change relative to filtered=0.
- Parameter rules: WIDTH or COUNT_W outside 1..32, or EDGE_MODE > 2, is a synthesis-time error.

Decomposition:
- Package eng_sim_in_pkg: address constants ADDR_DATA=0, ADDR_MASK=1, ADDR_COUNT=2, ADDR_EDGE=3; EDGE_MODE encodings EDGE_RISE/EDGE_FALL/EDGE_ANY.
- Sub-module eng_sim_in_filter: single-bit synchroniser plus stability filter, parameter FILTER_CYCLES, outputs filtered. Instantiated WIDTH times via generate.
- Top level holds edge detect, EDGE, MASK, COUNT, irq and the read mux.

Test Plan:
- Reset and bypass: reset held 2 cycles, then read all four addresses -> readdata 0, irq 0. With FILTER_CYCLES=0, in_port=8'hA5 -> DATA reads 8'hA5 after 3 edges.
- Glitch filter: FILTER_CYCLES=3, bit 2 pulsed high 2 cycles -> DATA stays 0, EDGE 0. Bit 2 held high 3 cycles -> DATA 8'h04 after 2+3 edges, EDGE 8'h04.
- Interrupt: MASK=8'h04, rising edge on bit 2 -> irq=1 one edge after EDGE sets. Write EDGE=8'h04 -> EDGE 0 and irq 0 next edge. MASK=0 with EDGE set -> irq 0.
- Set beats clear: W1C of bit 2 in the same cycle a new bit-2 edge is captured -> EDGE bit 2 remains 1.
- Counter: 10 clean bit-0 pulses -> COUNT 10. COUNT_W=4 with 20 pulses -> COUNT 15 (saturated). Write to address 2 coincident with an edge -> COUNT 1.
- Mid-op reset: reset asserted while the bit-5 filter count is 2 of 3 -> after release, DATA 0, EDGE 0, COUNT 0, irq 0, and the bit-5 change needs a full 2+3 edges again.
